// File: rtl/tinytpu_pkg.sv
// Shared tinytpu constants, host-link FSM states and frame-size helpers.
package tinytpu_pkg;

    localparam int unsigned DefDW   = 8;
    localparam int unsigned DefN    = 2;
    localparam int unsigned DefWord = 2;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StInit,
        StWait,
        StRecv,
        StDone
    } link_state_t;

    function automatic int unsigned frame_bits(int unsigned d_w, int unsigned n,
                                               int unsigned word);
        return n * word * d_w;
    endfunction

    function automatic int unsigned result_bits(int unsigned d_w, int unsigned n);
        return n * n * 2 * d_w;
    endfunction

    function automatic int unsigned cnt_width(int unsigned fb, int unsigned rb);
        return $clog2(((fb > rb) ? fb : rb) + 1);
    endfunction

endpackage

// File: rtl/tpu_link_piso.sv
// Parallel-load, left-shift serialiser; the register MSB is the serial output.
module tpu_link_piso #(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [Width-1:0] din,
    output logic             dout
);

    logic [Width-1:0] shift_q;

    // Zeros shift in, so the output returns to 0 once the whole frame is out.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
        end else if (load) begin
            shift_q <= din;
        end else if (shift) begin
            shift_q <= {shift_q[Width-2:0], 1'b0};
        end
    end

    assign dout = shift_q[Width-1];

endmodule

// File: rtl/tpu_host_link.sv
// Host end of the tinytpu bit-serial link: serialises an operand pair, pulses init and
// deserialises the result. Optional WAIT watchdog enabled by TPU_LINK_TIMEOUT_EN.
module tpu_host_link
    import tinytpu_pkg::*;
#(
    parameter int unsigned D_W    = DefDW,
    parameter int unsigned N      = DefN,
    parameter int unsigned WORD   = DefWord
`ifdef TPU_LINK_TIMEOUT_EN
    ,
    parameter int unsigned TO_CYC = 1024
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [N*WORD*D_W-1:0] x_vec,
    input  logic [N*WORD*D_W-1:0] y_vec,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [N*N*2*D_W-1:0]  res_data,
    output logic                  timeout,
    output logic                  data_in_x,
    output logic                  data_in_y,
    output logic                  load_en,
    output logic                  init,
    input  logic                  data_out_z,
    input  logic                  tx_ready
);

    localparam int unsigned FB   = frame_bits(D_W, N, WORD);
    localparam int unsigned RB   = result_bits(D_W, N);
    localparam int unsigned CntW = cnt_width(FB, RB);

    link_state_t     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [RB-1:0]   res_q;
    logic            load_en_q, load_en_d;
    logic            init_q, init_d;
    logic            cmd_ready_q, cmd_ready_d;
    logic            res_valid_q, res_valid_d;
    logic            accept, frame_shift, rx_start, rx_shift;
    logic            to_fire;

    assign accept      = (state_q == StIdle) && cmd_valid;
    assign frame_shift = (state_q == StLoad);
    assign rx_start    = (state_q == StWait) && tx_ready;
    assign rx_shift    = rx_start || (state_q == StRecv);

`ifdef TPU_LINK_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TO_CYC + 1);

    logic [WaitW-1:0] wait_q;
    logic             timeout_q;

    assign to_fire = (state_q == StWait) && !tx_ready && (wait_q == WaitW'(TO_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_q <= (state_q == StWait) ? wait_q + 1'b1 : '0;
            if (to_fire) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign timeout = timeout_q;
`else
    assign to_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    tpu_link_piso #(
        .Width(FB)
    ) u_piso_x (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(frame_shift),
        .din  (x_vec),
        .dout (data_in_x)
    );

    tpu_link_piso #(
        .Width(FB)
    ) u_piso_y (
        .clk  (clk),
        .rst  (rst),
        .load (accept),
        .shift(frame_shift),
        .din  (y_vec),
        .dout (data_in_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            load_en_q   <= 1'b0;
            init_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            load_en_q   <= load_en_d;
            init_q      <= init_d;
            cmd_ready_q <= cmd_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cmd_valid) state_d = StLoad;
            StLoad: if (cnt_q == CntW'(FB - 1)) state_d = StInit;
            StInit: state_d = StWait;
            StWait: begin
                if (tx_ready) begin
                    state_d = StRecv;
                end else if (to_fire) begin
                    state_d = StDone;
                end
            end
            StRecv: if (cnt_q == CntW'(RB - 1)) state_d = StDone;
            StDone: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bit 0 is taken in WAIT, so RECV starts counting at 1.
    always_comb begin
        cnt_d = '0;
        if ((state_q == StLoad) || (state_q == StRecv)) begin
            cnt_d = cnt_q + 1'b1;
        end else if (rx_start) begin
            cnt_d = CntW'(1);
        end
    end

    // Outputs are decoded from the next state and registered, so they never glitch.
    always_comb begin
        load_en_d   = (state_d == StLoad);
        init_d      = (state_d == StInit);
        cmd_ready_d = (state_d == StIdle);
        res_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (to_fire) begin
            res_q <= '0;
        end else if (rx_shift) begin
            res_q <= {res_q[RB-2:0], data_out_z};
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_q;
    assign load_en   = load_en_q;
    assign init      = init_q;

endmodule

// File: tb/tb_tpu_host_link.sv
// Directed bench for tpu_host_link with a transaction-timeline reference model.
module tb_tpu_host_link;

    localparam int FB = 32;
    localparam int RB = 64;
`ifdef TPU_LINK_TIMEOUT_EN
    localparam int TO = 16;
`endif

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] x_vec;
    logic [31:0] y_vec;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] res_data;
    logic        timeout;
    logic        data_in_x;
    logic        data_in_y;
    logic        load_en;
    logic        init;
    logic        data_out_z;
    logic        tx_ready;

    tpu_host_link #(
        .D_W (8),
        .N   (2),
        .WORD(2)
`ifdef TPU_LINK_TIMEOUT_EN
        ,
        .TO_CYC(TO)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .x_vec     (x_vec),
        .y_vec     (y_vec),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .timeout   (timeout),
        .data_in_x (data_in_x),
        .data_in_y (data_in_y),
        .load_en   (load_en),
        .init      (init),
        .data_out_z(data_out_z),
        .tx_ready  (tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: a transaction accepted at cycle acc drives the frame in acc+1..acc+FB,
    // pulses init at acc+FB+1 and listens for the core from acc+FB+2 onwards.
    int          cyc = 0;
    bit          armed = 0;
    int          acc = -1;
    int          rx_first = -1;
    int          nrx = 0;
    bit          holding = 0;
    bit          to_m = 0;
    logic [31:0] xm, ym;
    logic [63:0] racc, held;

    int          ld_cnt, init_cnt, init_cyc, first_ld;
    logic [31:0] xcap, ycap;

    initial begin
        forever begin
            int   c, k;
            bit   rel;
            logic el, ex, ey, ei;
            @(negedge clk);
            c = cyc;
            if (armed) begin
                el = (acc >= 0) && (c >= acc + 1) && (c <= acc + FB);
                ex = 1'b0;
                ey = 1'b0;
                if (el) begin
                    k  = FB - 1 - (c - acc - 1);
                    ex = xm[k];
                    ey = ym[k];
                end
                ei = (acc >= 0) && (c == acc + FB + 1);
                chk("cmd_ready", cmd_ready, acc < 0);
                chk("load_en", load_en, el);
                chk("data_in_x", data_in_x, ex);
                chk("data_in_y", data_in_y, ey);
                chk("init", init, ei);
                chk("res_valid", res_valid, holding);
                chk("timeout", timeout, to_m);
                if (rx_first < 0 || holding) chk("res_data", res_data, held);
            end
            if (load_en === 1'b1) begin
                if (ld_cnt == 0) first_ld = c;
                xcap = {xcap[30:0], data_in_x};
                ycap = {ycap[30:0], data_in_y};
                ld_cnt++;
            end
            if (init === 1'b1) begin
                init_cnt++;
                init_cyc = c;
            end
            // Advance the model with the inputs the DUT samples at the coming edge.
            if (rst) begin
                acc      = -1;
                rx_first = -1;
                nrx      = 0;
                holding  = 0;
                held     = '0;
                to_m     = 0;
                armed    = 1;
            end else if (armed) begin
                rel = holding && res_ready;
                if (acc < 0) begin
                    if (cmd_valid) begin
                        acc = c;
                        xm  = x_vec;
                        ym  = y_vec;
                    end
                end else if (!holding) begin
                    if (rx_first >= 0) begin
                        racc = {racc[62:0], data_out_z};
                        nrx++;
                    end else if (c >= acc + FB + 2) begin
                        if (tx_ready) begin
                            rx_first = c;
                            racc     = {63'b0, data_out_z};
                            nrx      = 1;
                        end
`ifdef TPU_LINK_TIMEOUT_EN
                        else if (c - (acc + FB + 2) == TO - 1) begin
                            holding = 1;
                            held    = '0;
                            to_m    = 1;
                        end
`endif
                    end
                    if (nrx == RB) begin
                        holding = 1;
                        held    = racc;
                        nrx     = 0;
                    end
                end
                if (rel) begin
                    acc      = -1;
                    rx_first = -1;
                    holding  = 0;
                end
            end
            cyc = c + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        ld_cnt   = 0;
        init_cnt = 0;
        init_cyc = -1;
        first_ld = -1;
        xcap     = '0;
        ycap     = '0;
    endtask

    // Core stand-in: waits for init, raises tx_ready dly cycles later and streams d MSB first.
    task automatic run_frame(input int dly, input logic [63:0] d);
        int n;
        n = 0;
        while (!init && n < 100) begin
            tick();
            n++;
        end
        chk("init_seen", init, 1'b1);
        if (dly == 0) begin
            tx_ready   = 1'b1;
            data_out_z = d[63];
            tick();
        end else begin
            repeat (dly) tick();
        end
        for (int i = 63; i >= 0; i--) begin
            tx_ready   = 1'b1;
            data_out_z = d[i];
            tick();
        end
        tx_ready   = 1'b0;
        data_out_z = 1'b0;
        n = 0;
        while (!res_valid && n < 50) begin
            tick();
            n++;
        end
        chk("res_valid_seen", res_valid, 1'b1);
    endtask

    initial begin
        int t_acc;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        x_vec      = '0;
        y_vec      = '0;
        res_ready  = 1'b0;
        data_out_z = 1'b0;
        tx_ready   = 1'b0;
        clear_caps();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_res_data", res_data, 64'h0);
        chk("rst_load_en", load_en, 1'b0);
        chk("rst_init", init, 1'b0);
        chk("rst_timeout", timeout, 1'b0);
        tick();

        // Abort a frame in its 10th LOAD cycle.
        x_vec     = 32'hDEAD_BEEF;
        y_vec     = 32'hCAFE_F00D;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (9) tick();
        chk("abort_pre_load_en", load_en, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_load_en", load_en, 1'b0);
        chk("abort_cmd_ready", cmd_ready, 1'b1);
        clear_caps();
        repeat (60) tick();
        chk("abort_no_init", init_cnt, 0);
        chk("abort_no_load", ld_cnt, 0);

        // Main frame; operands change right after acceptance.
        x_vec     = 32'hA5A5_0F0F;
        y_vec     = 32'h0102_0304;
        cmd_valid = 1'b1;
        clear_caps();
        t_acc = cyc;
        tick();
        cmd_valid = 1'b0;
        x_vec     = 32'hFFFF_FFFF;
        y_vec     = 32'hFFFF_FFFF;
        run_frame(5, 64'h0011_2233_4455_6677);
        chk("x_frame", xcap, 32'hA5A5_0F0F);
        chk("y_frame", ycap, 32'h0102_0304);
        chk("load_len", ld_cnt, 32);
        chk("load_start", first_ld, t_acc + 1);
        chk("init_cycle", init_cyc, t_acc + 33);
        chk("init_count", init_cnt, 1);
        chk("res_lit", res_data, 64'h0011_2233_4455_6677);

        // Result held back for 20 cycles while a new command knocks.
        res_ready = 1'b0;
        cmd_valid = 1'b1;
        x_vec     = 32'h1234_5678;
        y_vec     = 32'h9ABC_DEF0;
        repeat (20) tick();
        chk("hold_cmd_ready", cmd_ready, 1'b0);
        chk("hold_res_valid", res_valid, 1'b1);
        chk("hold_res_lit", res_data, 64'h0011_2233_4455_6677);

        // Back-to-back: result accepted with the command still pending.
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("b2b_cmd_ready", cmd_ready, 1'b1);
        chk("b2b_res_valid", res_valid, 1'b0);
        clear_caps();
        t_acc = cyc;
        tick();
        cmd_valid = 1'b0;
        run_frame(0, 64'hFEDC_BA98_7654_3210);
        chk("b2b_x_frame", xcap, 32'h1234_5678);
        chk("b2b_y_frame", ycap, 32'h9ABC_DEF0);
        chk("b2b_init_cycle", init_cyc, t_acc + 33);
        chk("b2b_res_lit", res_data, 64'hFEDC_BA98_7654_3210);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk("b2b_done_cmd_ready", cmd_ready, 1'b1);

`ifdef TPU_LINK_TIMEOUT_EN
        begin
            int n;
            x_vec     = 32'h0F0F_F0F0;
            y_vec     = 32'h3333_CCCC;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            n = 0;
            while (!res_valid && n < FB + TO + 20) begin
                tick();
                n++;
            end
            chk("to_res_valid", res_valid, 1'b1);
            chk("to_flag", timeout, 1'b1);
            chk("to_res_data", res_data, 64'h0);
            res_ready = 1'b1;
            tick();
            res_ready = 1'b0;
        end
`endif

        repeat (5) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "bench timed out");
    end

endmodule
